// File: rtl/exec_trace_monitor.sv
// exec_trace_monitor: samples execute lanes into packed trace records, buffers them in a
// valid/ready FIFO, keeps saturating statistics and detects halt on ecall/ebreak/timeout.
module exec_trace_monitor #(
    parameter int LANES          = 2,
    parameter int CNT_W          = 32,
    parameter int FIFO_DEPTH     = 8,
    parameter int HALT_ON_EBREAK = 1,
    parameter int HALT_ON_ECALL  = 1,
    localparam int TRACE_W       = CNT_W + 1 + 2*LANES + 64*LANES,
    localparam int LVL_W         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [CNT_W-1:0]      max_cycles,
    input  logic [LANES-1:0]      lane_valid,
    input  logic [32*LANES-1:0]   lane_instr,
    input  logic [32*LANES-1:0]   lane_result,
    input  logic [LANES-1:0]      lane_redirect,
    input  logic                  stall_in,
    output logic                  trace_valid,
    input  logic                  trace_ready,
    output logic [TRACE_W-1:0]    trace_data,
    output logic [CNT_W-1:0]      cycle_count,
    output logic [CNT_W-1:0]      retired_count,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      redirect_count,
    output logic [CNT_W-1:0]      drop_count,
    output logic [LVL_W-1:0]      fifo_level,
    output logic                  halted,
    output logic [1:0]            halt_cause,
    output logic [1:0]            halt_lane,
    output logic                  done
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [31:0] EBREAK = 32'h00100073;
    localparam logic [31:0] ECALL  = 32'h00000073;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                state;
    logic                  active, sys_hit, sys_ebreak, timeout;
    logic                  push_req, push_ok, pop, full, drop;
    logic [1:0]            sys_lane;
    logic [LANES-1:0]      eff_valid, eff_redir;
    logic [32*LANES-1:0]   instr_m, result_m;
    logic [TRACE_W-1:0]    rec;
    logic [TRACE_W-1:0]    mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] popcnt(input logic [LANES-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int k = 0; k < LANES; k++) c = c + CNT_W'(v[k]);
        return c;
    endfunction

    // Descending scan so the lowest-index halting lane is the one left standing
    always_comb begin
        sys_hit    = 1'b0;
        sys_ebreak = 1'b0;
        sys_lane   = 2'd0;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (lane_valid[k] &&
                ((HALT_ON_EBREAK != 0 && lane_instr[32*k +: 32] == EBREAK) ||
                 (HALT_ON_ECALL  != 0 && lane_instr[32*k +: 32] == ECALL))) begin
                sys_hit    = 1'b1;
                sys_ebreak = lane_instr[32*k +: 32] == EBREAK;
                sys_lane   = 2'(k);
            end
        end
        eff_valid = '0;
        eff_redir = '0;
        instr_m   = '0;
        result_m  = '0;
        for (int k = 0; k < LANES; k++) begin
            eff_valid[k]          = lane_valid[k] && (!sys_hit || 2'(k) <= sys_lane);
            eff_redir[k]          = eff_valid[k] && lane_redirect[k];
            instr_m[32*k +: 32]   = eff_valid[k] ? lane_instr[32*k +: 32]  : 32'd0;
            result_m[32*k +: 32]  = eff_valid[k] ? lane_result[32*k +: 32] : 32'd0;
        end
    end

    assign active      = state == RUN && enable;
    assign timeout     = max_cycles != '0 && cycle_count == max_cycles;
    assign rec         = {cycle_count, stall_in, eff_redir, eff_valid, instr_m, result_m};
    assign trace_valid = fifo_level != '0;
    assign trace_data  = mem[rd_ptr];
    assign full        = fifo_level == LVL_W'(FIFO_DEPTH);
    assign pop         = trace_valid && trace_ready;
    assign push_req    = active && (|lane_valid || stall_in);
    assign push_ok     = push_req && (!full || pop);
    assign drop        = push_req && full && !pop;
    assign done        = state == DONE;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= rec;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_level     <= '0;
            cycle_count    <= '0;
            retired_count  <= '0;
            stall_count    <= '0;
            redirect_count <= '0;
            drop_count     <= '0;
            halted         <= 1'b0;
            halt_cause     <= 2'd0;
            halt_lane      <= 2'd0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_level <= fifo_level + LVL_W'(push_ok) - LVL_W'(pop);
            if (active) begin
                cycle_count    <= sat_add(cycle_count, CNT_W'(1));
                retired_count  <= sat_add(retired_count, popcnt(eff_valid));
                stall_count    <= sat_add(stall_count, CNT_W'(stall_in));
                redirect_count <= sat_add(redirect_count, popcnt(eff_redir));
                if (drop) drop_count <= sat_add(drop_count, CNT_W'(1));
            end
            case (state)
                IDLE:  if (enable) state <= RUN;
                RUN: begin
                    if (active && (sys_hit || timeout)) begin
                        state      <= DRAIN;
                        halted     <= 1'b1;
                        halt_cause <= sys_hit ? (sys_ebreak ? 2'd1 : 2'd2) : 2'd3;
                        halt_lane  <= sys_hit ? sys_lane : 2'd0;
                    end
                end
                DRAIN: if (fifo_level == '0) state <= DONE;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_exec_trace_monitor.sv
// tb_exec_trace_monitor: directed scenario tasks for exec_trace_monitor (2 lanes, depth 8).
module tb_exec_trace_monitor;
    localparam int LANES = 2;
    localparam int CNT_W = 32;
    localparam int TW    = CNT_W + 1 + 2*LANES + 64*LANES;
    localparam logic [31:0] ADDI   = 32'h00500093;
    localparam logic [31:0] EBRK   = 32'h00100073;
    localparam logic [31:0] ECLL   = 32'h00000073;

    logic              clk = 1'b0;
    logic              rst, enable, stall_in, trace_ready;
    logic [CNT_W-1:0]  max_cycles;
    logic [LANES-1:0]  lane_valid, lane_redirect;
    logic [63:0]       lane_instr, lane_result;
    logic              trace_valid, halted, done;
    logic [TW-1:0]     trace_data;
    logic [CNT_W-1:0]  cycle_count, retired_count, stall_count, redirect_count, drop_count;
    logic [3:0]        fifo_level;
    logic [1:0]        halt_cause, halt_lane;

    int n_cmp = 0;
    int n_bad = 0;
    logic [TW-1:0] cap[$];

    exec_trace_monitor #(.LANES(2), .CNT_W(32), .FIFO_DEPTH(8), .HALT_ON_EBREAK(1), .HALT_ON_ECALL(1)) dut (
        .clk(clk), .rst(rst), .enable(enable), .max_cycles(max_cycles),
        .lane_valid(lane_valid), .lane_instr(lane_instr), .lane_result(lane_result),
        .lane_redirect(lane_redirect), .stall_in(stall_in),
        .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_data(trace_data),
        .cycle_count(cycle_count), .retired_count(retired_count), .stall_count(stall_count),
        .redirect_count(redirect_count), .drop_count(drop_count), .fifo_level(fifo_level),
        .halted(halted), .halt_cause(halt_cause), .halt_lane(halt_lane), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (!rst && trace_valid && trace_ready) cap.push_back(trace_data);

    function automatic logic [31:0] f_stamp(input logic [TW-1:0] r); return r[164:133]; endfunction
    function automatic logic f_stall(input logic [TW-1:0] r); return r[132]; endfunction
    function automatic logic [1:0] f_redir(input logic [TW-1:0] r); return r[131:130]; endfunction
    function automatic logic [1:0] f_valid(input logic [TW-1:0] r); return r[129:128]; endfunction
    function automatic logic [31:0] f_instr1(input logic [TW-1:0] r); return r[127:96]; endfunction
    function automatic logic [31:0] f_instr0(input logic [TW-1:0] r); return r[95:64]; endfunction
    function automatic logic [31:0] f_result0(input logic [TW-1:0] r); return r[31:0]; endfunction

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic idle_lanes();
        lane_valid = '0; lane_redirect = '0; lane_instr = '0; lane_result = '0; stall_in = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; max_cycles = '0; trace_ready = 1'b1; idle_lanes();
        step(2);
        rst = 1'b0;
        cap.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; lane_valid = 2'b11; stall_in = 1'b1; trace_ready = 1'b0; max_cycles = '0;
        lane_instr = {EBRK, ADDI}; lane_result = '0; lane_redirect = 2'b11;
        step(2);
        n_cmp++; if (cycle_count !== 32'd0) begin n_bad++; $display("FAIL reset_cycle: got %0d want 0", cycle_count); end
        n_cmp++; if (fifo_level !== 4'd0) begin n_bad++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        n_cmp++; if ({trace_valid, halted, done, halt_cause, halt_lane} !== 7'd0) begin n_bad++; $display("FAIL reset_flags: got %b want 0", {trace_valid, halted, done, halt_cause, halt_lane}); end
        n_cmp++; if ({retired_count, stall_count, redirect_count, drop_count} !== 128'd0) begin n_bad++; $display("FAIL reset_counters: got nonzero want 0"); end
    endtask

    task automatic test_basic();
        do_reset();
        enable = 1'b1; step();
        lane_valid = 2'b01; lane_instr = {32'd0, ADDI}; lane_result = {32'd0, 32'd5};
        step(3);
        idle_lanes(); enable = 1'b0; step();
        n_cmp++; if (cycle_count !== 32'd3) begin n_bad++; $display("FAIL basic_cycle: got %0d want 3", cycle_count); end
        n_cmp++; if (retired_count !== 32'd3) begin n_bad++; $display("FAIL basic_retired: got %0d want 3", retired_count); end
        n_cmp++; if (cap.size() !== 3) begin n_bad++; $display("FAIL basic_nrec: got %0d want 3", cap.size()); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (f_stamp(cap[i]) !== 32'(i)) begin n_bad++; $display("FAIL basic_stamp%0d: got %0d want %0d", i, f_stamp(cap[i]), i); end
        end
        n_cmp++; if (f_valid(cap[1]) !== 2'b01) begin n_bad++; $display("FAIL basic_vmask: got %b want 01", f_valid(cap[1])); end
        n_cmp++; if (f_instr0(cap[2]) !== ADDI || f_result0(cap[2]) !== 32'd5 || f_instr1(cap[2]) !== 32'd0) begin
            n_bad++; $display("FAIL basic_payload: got %h/%h/%h want %h/5/0", f_instr0(cap[2]), f_result0(cap[2]), f_instr1(cap[2]), ADDI); end
    endtask

    task automatic test_ebreak();
        do_reset();
        enable = 1'b1; step();
        lane_valid = 2'b11; lane_instr = {EBRK, ADDI}; lane_result = {32'd0, 32'd5};
        step();
        idle_lanes();
        n_cmp++; if ({halted, halt_cause, halt_lane} !== 5'b1_01_01) begin n_bad++; $display("FAIL ebreak_halt: got %b want 10101", {halted, halt_cause, halt_lane}); end
        n_cmp++; if (retired_count !== 32'd2) begin n_bad++; $display("FAIL ebreak_retired: got %0d want 2", retired_count); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL ebreak_early_done: got %b want 0", done); end
        for (int i = 0; i < 10 && !done; i++) step();
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL ebreak_done: got %b want 1", done); end
        n_cmp++; if (cap.size() !== 1 || f_valid(cap[0]) !== 2'b11 || f_instr1(cap[0]) !== EBRK) begin
            n_bad++; $display("FAIL ebreak_rec: got n=%0d vmask=%b i1=%h want 1/11/%h", cap.size(), f_valid(cap[0]), f_instr1(cap[0]), EBRK); end
        n_cmp++; if (cycle_count !== 32'd1 || fifo_level !== 4'd0) begin n_bad++; $display("FAIL ebreak_hold: got cyc=%0d lvl=%0d want 1/0", cycle_count, fifo_level); end
    endtask

    task automatic test_priority();
        do_reset();
        enable = 1'b1; step();
        lane_valid = 2'b11; lane_instr = {ADDI, ECLL}; lane_result = {32'd7, 32'd0}; lane_redirect = 2'b10;
        step();
        idle_lanes();
        n_cmp++; if ({halted, halt_cause, halt_lane} !== 5'b1_10_00) begin n_bad++; $display("FAIL prio_halt: got %b want 11000", {halted, halt_cause, halt_lane}); end
        n_cmp++; if (retired_count !== 32'd1 || redirect_count !== 32'd0) begin n_bad++; $display("FAIL prio_counts: got ret=%0d red=%0d want 1/0", retired_count, redirect_count); end
        for (int i = 0; i < 10 && !done; i++) step();
        n_cmp++; if (cap.size() !== 1 || f_valid(cap[0]) !== 2'b01 || f_redir(cap[0]) !== 2'b00 || f_instr1(cap[0]) !== 32'd0) begin
            n_bad++; $display("FAIL prio_rec: got n=%0d vmask=%b rmask=%b i1=%h want 1/01/00/0", cap.size(), f_valid(cap[0]), f_redir(cap[0]), f_instr1(cap[0])); end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL prio_done: got %b want 1", done); end
    endtask

    task automatic test_timeout();
        do_reset();
        max_cycles = 32'd10; enable = 1'b1; step();
        step(10);
        n_cmp++; if (halted !== 1'b0 || cycle_count !== 32'd10) begin n_bad++; $display("FAIL tmo_before: got h=%b cyc=%0d want 0/10", halted, cycle_count); end
        step();
        n_cmp++; if ({halted, halt_cause, halt_lane} !== 5'b1_11_00) begin n_bad++; $display("FAIL tmo_halt: got %b want 11100", {halted, halt_cause, halt_lane}); end
        n_cmp++; if (cycle_count !== 32'd11 || done !== 1'b0) begin n_bad++; $display("FAIL tmo_cycle: got cyc=%0d done=%b want 11/0", cycle_count, done); end
        step();
        n_cmp++; if (done !== 1'b1 || cap.size() !== 0 || cycle_count !== 32'd11) begin n_bad++; $display("FAIL tmo_done: got done=%b n=%0d cyc=%0d want 1/0/11", done, cap.size(), cycle_count); end
    endtask

    task automatic test_backpressure();
        do_reset();
        trace_ready = 1'b0; enable = 1'b1; step();
        lane_valid = 2'b01; lane_instr = {32'd0, ADDI}; lane_result = {32'd0, 32'd9}; stall_in = 1'b1;
        step(12);
        n_cmp++; if (fifo_level !== 4'd8 || drop_count !== 32'd4) begin n_bad++; $display("FAIL bp_full: got lvl=%0d drop=%0d want 8/4", fifo_level, drop_count); end
        n_cmp++; if (trace_valid !== 1'b1 || f_stamp(trace_data) !== 32'd0) begin n_bad++; $display("FAIL bp_head: got v=%b stamp=%0d want 1/0", trace_valid, f_stamp(trace_data)); end
        trace_ready = 1'b1; step();
        n_cmp++; if (fifo_level !== 4'd8 || drop_count !== 32'd4 || stall_count !== 32'd13) begin
            n_bad++; $display("FAIL bp_pushpop: got lvl=%0d drop=%0d stall=%0d want 8/4/13", fifo_level, drop_count, stall_count); end
        enable = 1'b0; step(8);
        n_cmp++; if (fifo_level !== 4'd0 || cap.size() !== 9) begin n_bad++; $display("FAIL bp_drain: got lvl=%0d n=%0d want 0/9", fifo_level, cap.size()); end
        for (int i = 0; i < 9; i++) begin
            n_cmp++; if (f_stamp(cap[i]) !== (i == 8 ? 32'd12 : 32'(i)) || f_stall(cap[i]) !== 1'b1) begin
                n_bad++; $display("FAIL bp_order%0d: got stamp=%0d stall=%b want %0d/1", i, f_stamp(cap[i]), f_stall(cap[i]), i == 8 ? 12 : i); end
        end
    endtask

    task automatic test_pause_reset();
        do_reset();
        trace_ready = 1'b0; enable = 1'b1; step();
        lane_valid = 2'b01; lane_instr = {32'd0, ADDI};
        step(3);
        enable = 1'b0; step(5);
        n_cmp++; if (cycle_count !== 32'd3 || retired_count !== 32'd3 || fifo_level !== 4'd3) begin
            n_bad++; $display("FAIL pause_frozen: got cyc=%0d ret=%0d lvl=%0d want 3/3/3", cycle_count, retired_count, fifo_level); end
        enable = 1'b1; rst = 1'b1; step();
        n_cmp++; if (cycle_count !== 32'd0 || retired_count !== 32'd0 || fifo_level !== 4'd0 || trace_valid !== 1'b0) begin
            n_bad++; $display("FAIL midrun_reset: got cyc=%0d ret=%0d lvl=%0d v=%b want 0/0/0/0", cycle_count, retired_count, fifo_level, trace_valid); end
        rst = 1'b0; step();
        n_cmp++; if (cycle_count !== 32'd0 || fifo_level !== 4'd0) begin n_bad++; $display("FAIL reset_idle: got cyc=%0d lvl=%0d want 0/0", cycle_count, fifo_level); end
        step();
        n_cmp++; if (cycle_count !== 32'd1 || fifo_level !== 4'd1) begin n_bad++; $display("FAIL restart_run: got cyc=%0d lvl=%0d want 1/1", cycle_count, fifo_level); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ebreak();
        test_priority();
        test_timeout();
        test_backpressure();
        test_pause_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/exec_trace_monitor.md
Name: exec_trace_monitor

Overview:
- Synthesizable execution-trace and halt monitor for the multi-issue RV32I core. It is the hardware successor to the bench-only per-cycle tracer.
- Each cycle it samples N execute lanes, then builds a packed trace record and buffers it in a FIFO with a valid/ready drain port.
- It keeps cycle, retire, stall, redirect and drop counters, and detects halt on ECALL, EBREAK or cycle timeout.
- It sits beside rv32i_cpu and taps the execute-stage debug signals.

Parameters:
- LANES, 2, number of execute lanes sampled (1..4).
- CNT_W, 32, width of all counters and of the cycle stamp.
- FIFO_DEPTH, 8, number of trace records buffered; power of 2, ≥2.
- HALT_ON_EBREAK, 1, when 1, instruction 32'h00100073 triggers a halt.
- HALT_ON_ECALL, 1, when 1, instruction 32'h00000073 triggers a halt.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- enable  in  1  run/pause control.
- max_cycles  in  CNT_W  timeout limit; 0 disables the timeout.
- lane_valid  in  LANES  lane k holds an executing instruction this cycle.
- lane_instr  in  32*LANES  instruction of lane k, at bits [32k+31:32k].
- lane_result  in  32*LANES  execute result of lane k.
- lane_redirect  in  LANES  branch or jump taken in lane k.
- stall_in  in  1  front-end stall this cycle.
- trace_valid  out  1  FIFO head holds a record.
- trace_ready  in  1  consumer accepts the head record.
- trace_data  out  TRACE_W  head record.
- cycle_count, retired_count, stall_count, redirect_count, drop_count  out  CNT_W each  statistics counters.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.
- halted  out  1  halt has been detected.
- halt_cause  out  2  0 = none, 1 = ebreak, 2 = ecall, 3 = timeout.
- halt_lane  out  2  lane that caused the halt; 0 when the cause is timeout.
- done  out  1  halted and FIFO drained.

Behaviour:
- Reset: synchronous, active-high. It wins over every other input, including a reset during RUN, DRAIN or DONE.
  - All outputs are 0 after reset: counters, fifo_level, trace_valid, halted, halt_cause, halt_lane, done.
  - The FIFO is emptied, its contents are don't-care, and the FSM goes to IDLE.
- TRACE_W = CNT_W + 1 + 2*LANES + 64*LANES. Record layout, MSB to LSB:
  - cycle stamp, then stall,
  - redirect mask[LANES-1:0], then effective valid mask[LANES-1:0],
  - instr lanes LANES-1..0, then result lanes LANES-1..0.
  - Invalid lanes carry zeros in their instr, result and redirect fields.
- FSM states IDLE, RUN, DRAIN, DONE:
  - IDLE -> RUN when enable=1. No sampling happens in IDLE.
  - RUN with enable=0: pause. Counters freeze, nothing is pushed, the state stays RUN, and draining continues.
  - RUN with enable=1: this is an active cycle. The cycle stamp is the pre-increment cycle_count, and cycle_count increments.
  - RUN -> DRAIN on halt detection. The record of the halting cycle is still pushed.
  - DRAIN -> DONE when fifo_level==0 and no push is pending. In DRAIN no sampling or counting happens, but pops continue.
  - DONE: `done=1` and all state is held until rst.
- Halt detection, in active cycles only:
  - System halt: the lowest-index valid lane whose instr matches an enabled system opcode. It sets halt_cause (ecall=2, ebreak=1) and halt_lane.
  - Lanes with a higher index than the halting lane are masked out of the effective valid mask, retired_count and redirect_count.
  - Timeout: pre-increment cycle_count == max_cycles with max_cycles≠0 gives cause 3 and halt_lane=0.
  - If a system halt and a timeout occur in the same cycle, the system cause wins.
- Counters, in active cycles only:
  - retired_count += popcount of the effective valid mask.
  - stall_count += stall_in.
  - redirect_count += popcount of (redirect & effective valid).
  - All counters saturate at 2^CNT_W-1 and never wrap.
- Push rule:
  - A record is pushed in an active cycle when any lane is valid or stall_in=1. Idle cycles (no valid lanes, no stall) are not recorded but are still counted.
  - If the FIFO is full and no pop happens in the same cycle, the record is dropped and drop_count increments (saturating).
  - A push and a pop in the same cycle while full succeeds; fifo_level is unchanged.
- Pop rule:
  - A pop happens when trace_valid && trace_ready.
  - trace_data is the registered FIFO head and is stable while trace_valid=1 and trace_ready=0.
  - Push-to-trace_valid latency is 1 cycle: a record pushed at edge t is visible after edge t.
  - The FIFO read and write pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Basic trace: rst 2 cycles, enable=1, lane0 valid with instr 32'h00500093 and result 5 for 3 cycles, trace_ready=1 -> 3 records with stamps 0,1,2, valid mask 2'b01, retired_count=3, cycle_count=3.
- Dual-lane EBREAK: lane0 addi, lane1 32'h00100073 in the same cycle -> halted=1, cause=1, halt_lane=1, retired_count +2. Then DRAIN, and done=1 once the FIFO is empty.
- Priority masking: lane0 ECALL, lane1 valid with redirect=1 -> cause=2, halt_lane=0, record valid mask 2'b01, redirect_count unchanged, retired +1.
- Timeout: max_cycles=10, only idle cycles -> halt at stamp 10 with cause 3, no records pushed, cycle_count=11, done the following cycle.
- Backpressure: trace_ready=0 for 12 active cycles at FIFO_DEPTH=8 -> fifo_level=8, drop_count=4. Then trace_ready=1 -> 8 records with stamps 0..7 in order. A push and pop while full keeps the level at 8.
- Pause and reset: enable=0 for 5 cycles in RUN -> counters frozen and no pushes. Asserting rst mid-RUN with 3 entries buffered -> next cycle all outputs 0 and state IDLE.
